// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mult_seq_pkg;

  localparam int WIDTH_DEF = 16;  // default operand width
  localparam int STEPS     = 16;  // Booth steps per multiply
  localparam int CNT_W     = 5;   // step counter width (counts 0..16)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_seq_if.sv
// Request/result bundle of the multiplier.
// Handshake: start is sampled only while the block is idle; busy is high
// for the whole calculation; done is a one-cycle pulse marking the cycle in
// which Hi/Lo first show the new product. Hi/Lo hold until the next done.
interface mult_seq_if import mult_seq_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) ();
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (output start, A, B, input busy, done, Hi, Lo);
  modport slave  (input start, A, B, output busy, done, Hi, Lo);
endinterface

// File: rtl/mult_seq_booth_step.sv
// One radix-2 Booth step: conditional add/subtract of the multiplicand
// followed by an arithmetic right shift of {acc, q, q_m1}.
module booth_step import mult_seq_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q_m1_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q_m1_o
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  // Add/subtract chosen by {q0, q-1}, then shift the whole triple right.
  always_comb begin
    m_ext = {m_i[WIDTH-1], m_i};
    sum   = acc_i;
    case ({q_i[0], q_m1_i})
      2'b01:   sum = acc_i + m_ext;
      2'b10:   sum = acc_i - m_ext;
      default: sum = acc_i;
    endcase
    acc_o  = {sum[WIDTH], sum[WIDTH:1]};
    q_o    = {sum[0], q_i[WIDTH-1:1]};
    q_m1_o = q_i[0];
  end

endmodule

// File: rtl/mult_seq.sv
// Sequential signed multiplier: 16 Booth steps, fixed latency, results
// registered so no input reaches an output combinationally.
module mult_seq import mult_seq_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  mult_seq_if.slave    bus,
  output state_e       dbg_state
);

  state_e             state_q, state_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q_m1_q, q_m1_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     acc_nx;
  logic [WIDTH-1:0]   q_nx;
  logic               q_m1_nx;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_i  (acc_q),
    .q_i    (q_q),
    .q_m1_i (q_m1_q),
    .m_i    (m_q),
    .acc_o  (acc_nx),
    .q_o    (q_nx),
    .q_m1_o (q_m1_nx)
  );

  // Next-state and datapath updates; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q_m1_d  = q_m1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          q_d     = bus.B;
          q_m1_d  = 1'b0;
          m_d     = bus.A;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = acc_nx;
        q_d    = q_nx;
        q_m1_d = q_m1_nx;
        cnt_d  = cnt_q + CNT_W'(1);
        // Last step: publish the product on the same edge as the step.
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          hi_d    = acc_nx[WIDTH-1:0];
          lo_d    = q_nx;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      q_m1_q  <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q_m1_q  <= q_m1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy  = (state_q == CALC);
  assign bus.done  = (state_q == DONE);
  assign bus.Hi    = hi_q;
  assign bus.Lo    = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed and back-to-back bench for the sequential Booth multiplier.
module tb_mult_seq;
  import mult_seq_pkg::*;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;
  int     n_cmp = 0;
  int     n_err = 0;
  logic [31:0] exp_q[$];

  mult_seq_if #(.WIDTH(16)) bus ();

  mult_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return 32'(sa * sb);
  endfunction

  // Driver: issue one request and wait (bounded) for done.
  // lat counts edges after the accepting edge; busy_cnt counts busy cycles.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] prod, output int lat,
                       output int busy_cnt, output bit ok);
    @(posedge clk); #1;
    bus.A = a; bus.B = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; busy_cnt = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    prod = {bus.Hi, bus.Lo};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.A = '0; bus.B = '0;
    #3;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_cmp++; if ({bus.Hi, bus.Lo} !== 32'h0) begin n_err++; $display("FAIL reset_hilo got %h want 0", {bus.Hi, bus.Lo}); end
    n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] va[5];
    logic [15:0] vb[5];
    logic [31:0] ve[5];
    logic [31:0] prod;
    int lat, bc;
    bit ok;
    va[0] = 16'd3;    vb[0] = 16'd5;    ve[0] = 32'h0000_000F;
    va[1] = 16'hFFF9; vb[1] = 16'd6;    ve[1] = 32'hFFFF_FFD6;
    va[2] = 16'h8000; vb[2] = 16'h8000; ve[2] = 32'h4000_0000;
    va[3] = 16'h7FFF; vb[3] = 16'h8000; ve[3] = 32'hC000_8000;
    va[4] = 16'd1234; vb[4] = 16'd0;    ve[4] = 32'h0000_0000;
    for (int v = 0; v < 5; v++) begin
      do_op(va[v], vb[v], prod, lat, bc, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL dir%0d_timeout no done within 40 cycles", v); end
      n_cmp++; if (prod !== ve[v]) begin n_err++; $display("FAIL dir%0d_prod got %h want %h", v, prod, ve[v]); end
      n_cmp++; if (lat != 16) begin n_err++; $display("FAIL dir%0d_latency got %0d want 16", v, lat); end
      n_cmp++; if (bc != 16) begin n_err++; $display("FAIL dir%0d_busy got %0d want 16", v, bc); end
      // Done is a single pulse and the result holds while inputs wander.
      bus.A = 16'h5A5A; bus.B = 16'hA5A5;
      @(posedge clk); #1;
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_pulse got %b want 0", v, bus.done); end
      @(posedge clk); #1;
      n_cmp++; if ({bus.Hi, bus.Lo} !== ve[v]) begin n_err++; $display("FAIL dir%0d_hold got %h want %h", v, {bus.Hi, bus.Lo}, ve[v]); end
    end
  endtask

  task automatic test_ignore_start();
    int done_cnt;
    logic [31:0] got;
    @(posedge clk); #1;
    bus.A = 16'h0011; bus.B = 16'h0003; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_cnt = 0; got = '0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) begin bus.A = 16'h7777; bus.B = 16'h0002; bus.start = 1'b1; end
      if (i == 6) bus.start = 1'b0;
      if (bus.done) begin done_cnt++; got = {bus.Hi, bus.Lo}; end
      @(posedge clk); #1;
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL ignore_done_count got %0d want 1", done_cnt); end
    n_cmp++; if (got !== 32'h0000_0033) begin n_err++; $display("FAIL ignore_prod got %h want 00000033", got); end
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    logic [31:0] prod;
    int lat, bc;
    bit ok;
    @(posedge clk); #1;
    bus.A = 16'h0100; bus.B = 16'h0100; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.Hi, bus.Lo} !== 32'h0) begin n_err++; $display("FAIL midrst_hilo got %h want 0", {bus.Hi, bus.Lo}); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL midrst_state got %0d want 0", dbg_state); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.done) done_cnt++;
    end
    n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL midrst_no_done got %0d pulses want 0", done_cnt); end
    do_op(16'd2, 16'hFFFE, prod, lat, bc, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL midrst_after_timeout no done within 40 cycles"); end
    n_cmp++; if (prod !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL midrst_after_prod got %h want fffffffc", prod); end
    n_cmp++; if (lat != 16) begin n_err++; $display("FAIL midrst_after_latency got %0d want 16", lat); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    logic [31:0] exp_v, got;
    int cyc, last_done;
    bit found;
    @(posedge clk); #1;
    a = 16'($urandom_range(0, 65535));
    b = 16'($urandom_range(0, 65535));
    bus.A = a; bus.B = b; bus.start = 1'b1;
    exp_q.push_back(ref_mul(a, b));
    cyc = 0; last_done = 0;
    for (int i = 0; i < 1000; i++) begin
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        cyc++;
        if (bus.done) begin found = 1'b1; break; end
      end
      n_cmp++;
      if (!found) begin
        n_err++; $display("FAIL b2b_timeout op %0d no done within 40 cycles", i);
        break;
      end
      got = {bus.Hi, bus.Lo};
      exp_v = exp_q.pop_front();
      n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL b2b_prod op %0d got %h want %h", i, got, exp_v); end
      if (i > 0) begin
        n_cmp++; if (cyc - last_done != 18) begin n_err++; $display("FAIL b2b_interval op %0d got %0d want 18", i, cyc - last_done); end
      end
      last_done = cyc;
      // Still in DONE here: new operands are captured two edges later.
      if (i < 999) begin
        a = 16'($urandom_range(0, 65535));
        b = 16'($urandom_range(0, 65535));
        bus.A = a; bus.B = b;
        exp_q.push_back(ref_mul(a, b));
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL b2b_final_state got %0d want 0", dbg_state); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
